// File: rtl/ahb_bm_pkg.sv
// Shared definitions for the AHB bus-matrix output stage: HTRANS encodings,
// the "no port" marker and bus field widths.
package ahb_bm_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int PROT_W  = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 3;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Port index used when no input owns the MI.
  localparam logic [1:0] PORT_NONE = 2'b11;

  // Round-robin successor over the three input ports (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] rr_next(input logic [1:0] port);
    return (port == 2'd2) ? 2'd0 : port + 2'd1;
  endfunction

endpackage

// File: rtl/ahb_bm_rr_arb3.sv
// Three-input round-robin arbiter for one MI port. Keeps the last address-phase
// owner and holds the grant through bursts (SEQ/BUSY) and locked sequences.
module ahb_bm_rr_arb3
  import ahb_bm_pkg::*;
#(
  parameter int PARK_PORT = 0,
  parameter int LOCK_HOLD = 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [2:0] sel_i,
  input  logic [5:0] trans_i,     // {trans2, trans1, trans0}
  input  logic [2:0] mastlock_i,
  input  logic       hready_i,
  output logic [1:0] owner_o      // PORT_NONE when nobody is granted
);

  localparam logic [1:0] PARK    = 2'(PARK_PORT);
  localparam logic       LOCK_EN = (LOCK_HOLD != 0);

  logic [1:0] last_owner_q, last_owner_d;
  logic [2:0] req;
  logic       own_sel, own_lock, hold;
  logic [1:0] own_trans;
  logic [1:0] cand;

  // A port requests on NONSEQ or SEQ; BUSY only keeps an existing grant.
  assign req = {sel_i[2] & trans_i[5], sel_i[1] & trans_i[3], sel_i[0] & trans_i[1]};

  // Look up the last owner's current bus signals to evaluate the hold condition.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    own_sel   = 1'b0;
    own_trans = HTRANS_IDLE;
    own_lock  = 1'b0;
    case (last_owner_q)
      2'd0:    begin own_sel = sel_i[0]; own_trans = trans_i[1:0]; own_lock = mastlock_i[0]; end
      2'd1:    begin own_sel = sel_i[1]; own_trans = trans_i[3:2]; own_lock = mastlock_i[1]; end
      2'd2:    begin own_sel = sel_i[2]; own_trans = trans_i[5:4]; own_lock = mastlock_i[2]; end
      default: ;
    endcase
    hold = own_sel & ((own_trans == HTRANS_SEQ) | (own_trans == HTRANS_BUSY) |
                      (LOCK_EN & own_lock));
  end

  // Next owner: keep a held owner, otherwise scan starting after the last owner.
  always_comb begin
    owner_o = PORT_NONE;
    cand    = last_owner_q;
    if (hold) begin
      owner_o = last_owner_q;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cand = rr_next(cand);
        if (owner_o == PORT_NONE && req[cand]) owner_o = cand;
      end
    end
  end

  // Ownership only advances on an accepted address phase with a real owner.
  assign last_owner_d = (hready_i && owner_o != PORT_NONE) ? owner_o : last_owner_q;

  // Last-owner register; returns to the park port on reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) last_owner_q <= PARK;
    else          last_owner_q <= last_owner_d;
  end

endmodule

// File: rtl/ahb_bm_outstage_mi.sv
// Bus-matrix output stage for one MI port: arbitrates the three input-stage
// requests, muxes the owner's address/control onto the MI bus and the
// data-phase owner's write data one cycle later.
module ahb_bm_outstage_mi
  import ahb_bm_pkg::*;
#(
  parameter int PARK_PORT = 0,
  parameter int LOCK_HOLD = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        sel_op0, sel_op1, sel_op2,
  input  logic [31:0] addr_op0, addr_op1, addr_op2,
  input  logic [1:0]  trans_op0, trans_op1, trans_op2,
  input  logic        write_op0, write_op1, write_op2,
  input  logic [2:0]  size_op0, size_op1, size_op2,
  input  logic [2:0]  burst_op0, burst_op1, burst_op2,
  input  logic [3:0]  prot_op0, prot_op1, prot_op2,
  input  logic        mastlock_op0, mastlock_op1, mastlock_op2,
  input  logic [31:0] wdata_op0, wdata_op1, wdata_op2,
  input  logic        held_tran_op0, held_tran_op1, held_tran_op2,
  input  logic        HREADYOUTM,
  output logic        active_op0, active_op1, active_op2,
  output logic        HSELM,
  output logic [31:0] HADDRM,
  output logic [1:0]  HTRANSM,
  output logic        HWRITEM,
  output logic [2:0]  HSIZEM,
  output logic [2:0]  HBURSTM,
  output logic [3:0]  HPROTM,
  output logic        HMASTLOCKM,
  output logic [31:0] HWDATAM,
  output logic        HREADYMUXM
);

  localparam logic [1:0] PARK = 2'(PARK_PORT);

  logic [1:0]         addr_in_port, mux_port;
  logic [1:0]         data_in_port_q, data_in_port_d;
  logic               owned;
  logic               m_sel, m_write, m_lock;
  logic [ADDR_W-1:0]  m_addr;
  logic [1:0]         m_trans;
  logic [SIZE_W-1:0]  m_size;
  logic [BURST_W-1:0] m_burst;
  logic [PROT_W-1:0]  m_prot;
  logic               unused_held;

  // Held-transfer flags are informational here; ownership is tracked by the arbiter.
  assign unused_held = held_tran_op0 ^ held_tran_op1 ^ held_tran_op2;

  ahb_bm_rr_arb3 #(
    .PARK_PORT (PARK_PORT),
    .LOCK_HOLD (LOCK_HOLD)
  ) u_arb (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .sel_i      ({sel_op2, sel_op1, sel_op0}),
    .trans_i    ({trans_op2, trans_op1, trans_op0}),
    .mastlock_i ({mastlock_op2, mastlock_op1, mastlock_op0}),
    .hready_i   (HREADYOUTM),
    .owner_o    (addr_in_port)
  );

  assign owned    = (addr_in_port != PORT_NONE);
  assign mux_port = owned ? addr_in_port : PARK;

  // Address/control mux; with no owner the park port drives the passive fields.
  always_comb begin
    m_sel   = sel_op0;   m_addr  = addr_op0;  m_trans = trans_op0; m_write = write_op0;
    m_size  = size_op0;  m_burst = burst_op0; m_prot  = prot_op0;  m_lock  = mastlock_op0;
    case (mux_port)
      2'd1: begin
        m_sel   = sel_op1;   m_addr  = addr_op1;  m_trans = trans_op1; m_write = write_op1;
        m_size  = size_op1;  m_burst = burst_op1; m_prot  = prot_op1;  m_lock  = mastlock_op1;
      end
      2'd2: begin
        m_sel   = sel_op2;   m_addr  = addr_op2;  m_trans = trans_op2; m_write = write_op2;
        m_size  = size_op2;  m_burst = burst_op2; m_prot  = prot_op2;  m_lock  = mastlock_op2;
      end
      default: ;
    endcase
  end

  assign HSELM      = owned ? m_sel   : 1'b0;
  assign HTRANSM    = owned ? m_trans : HTRANS_IDLE;
  assign HMASTLOCKM = owned ? m_lock  : 1'b0;
  assign HADDRM     = m_addr;
  assign HWRITEM    = m_write;
  assign HSIZEM     = m_size;
  assign HBURSTM    = m_burst;
  assign HPROTM     = m_prot;
  assign HREADYMUXM = HREADYOUTM;

  assign active_op0 = sel_op0 & (addr_in_port == 2'd0);
  assign active_op1 = sel_op1 & (addr_in_port == 2'd1);
  assign active_op2 = sel_op2 & (addr_in_port == 2'd2);

  // A data phase exists only for a selected, non-IDLE accepted address phase.
  assign data_in_port_d = !HREADYOUTM ? data_in_port_q :
                          (HSELM && HTRANSM != HTRANS_IDLE) ? addr_in_port : PORT_NONE;

  // Data-phase owner register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) data_in_port_q <= PORT_NONE;
    else          data_in_port_q <= data_in_port_d;
  end

  // Write-data mux follows the data-phase owner; zero when idle.
  always_comb begin
    HWDATAM = '0;
    case (data_in_port_q)
      2'd0:    HWDATAM = wdata_op0;
      2'd1:    HWDATAM = wdata_op1;
      2'd2:    HWDATAM = wdata_op2;
      default: HWDATAM = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_bm_outstage_mi.sv
// Directed bench for ahb_bm_outstage_mi: the bench states the expected owner of
// every cycle; data-phase write data expectations flow through a queue.
module tb_ahb_bm_outstage_mi;
  import ahb_bm_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HREADYOUTM;
  logic        tb_sel   [3];
  logic [31:0] tb_addr  [3];
  logic [1:0]  tb_trans [3];
  logic        tb_write [3];
  logic [2:0]  tb_size  [3];
  logic [2:0]  tb_burst [3];
  logic [3:0]  tb_prot  [3];
  logic        tb_lock  [3];
  logic [31:0] tb_wdata [3];
  logic        tb_held  [3];

  logic        active_op0, active_op1, active_op2;
  logic        HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [31:0] HADDRM, HWDATAM;
  logic [1:0]  HTRANSM;
  logic [2:0]  HSIZEM, HBURSTM;
  logic [3:0]  HPROTM;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];

  ahb_bm_outstage_mi #(.PARK_PORT(0), .LOCK_HOLD(1)) dut (
    .HCLK (HCLK), .HRESETn (HRESETn),
    .sel_op0 (tb_sel[0]), .sel_op1 (tb_sel[1]), .sel_op2 (tb_sel[2]),
    .addr_op0 (tb_addr[0]), .addr_op1 (tb_addr[1]), .addr_op2 (tb_addr[2]),
    .trans_op0 (tb_trans[0]), .trans_op1 (tb_trans[1]), .trans_op2 (tb_trans[2]),
    .write_op0 (tb_write[0]), .write_op1 (tb_write[1]), .write_op2 (tb_write[2]),
    .size_op0 (tb_size[0]), .size_op1 (tb_size[1]), .size_op2 (tb_size[2]),
    .burst_op0 (tb_burst[0]), .burst_op1 (tb_burst[1]), .burst_op2 (tb_burst[2]),
    .prot_op0 (tb_prot[0]), .prot_op1 (tb_prot[1]), .prot_op2 (tb_prot[2]),
    .mastlock_op0 (tb_lock[0]), .mastlock_op1 (tb_lock[1]), .mastlock_op2 (tb_lock[2]),
    .wdata_op0 (tb_wdata[0]), .wdata_op1 (tb_wdata[1]), .wdata_op2 (tb_wdata[2]),
    .held_tran_op0 (tb_held[0]), .held_tran_op1 (tb_held[1]), .held_tran_op2 (tb_held[2]),
    .HREADYOUTM (HREADYOUTM),
    .active_op0 (active_op0), .active_op1 (active_op1), .active_op2 (active_op2),
    .HSELM (HSELM), .HADDRM (HADDRM), .HTRANSM (HTRANSM), .HWRITEM (HWRITEM),
    .HSIZEM (HSIZEM), .HBURSTM (HBURSTM), .HPROTM (HPROTM),
    .HMASTLOCKM (HMASTLOCKM), .HWDATAM (HWDATAM), .HREADYMUXM (HREADYMUXM)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
    end
  endtask

  task automatic drive_req(input int p, input logic [1:0] tr, input logic [31:0] a,
                           input logic [2:0] burst, input logic lk, input logic wr);
    tb_sel[p]   = 1'b1;
    tb_trans[p] = tr;
    tb_addr[p]  = a;
    tb_burst[p] = burst;
    tb_lock[p]  = lk;
    tb_write[p] = wr;
  endtask

  task automatic drive_idle(input int p);
    tb_sel[p]   = 1'b0;
    tb_trans[p] = HTRANS_IDLE;
    tb_lock[p]  = 1'b0;
  endtask

  // One bus cycle, entered just after a falling edge with inputs already driven.
  task automatic cycle(input string tag, input logic rdy, input logic [1:0] own);
    logic        v;
    logic [1:0]  mp;
    logic [31:0] exp_wd;
    HREADYOUTM = rdy;
    #1;
    v      = (own != PORT_NONE);
    mp     = v ? own : 2'd0;
    exp_wd = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    check(tag, "active", {29'd0, active_op2, active_op1, active_op0},
          v ? 32'(3'b001 << own) : 32'h0);
    check(tag, "hsel",   {31'd0, HSELM}, {31'd0, v});
    check(tag, "haddr",  HADDRM, tb_addr[mp]);
    check(tag, "htrans", {30'd0, HTRANSM}, v ? {30'd0, tb_trans[mp]} : 32'h0);
    check(tag, "ctrl",   {21'd0, HWRITEM, HSIZEM, HBURSTM, HPROTM},
          {21'd0, tb_write[mp], tb_size[mp], tb_burst[mp], tb_prot[mp]});
    check(tag, "hlock",  {31'd0, HMASTLOCKM}, v ? {31'd0, tb_lock[mp]} : 32'h0);
    check(tag, "hready", {31'd0, HREADYMUXM}, {31'd0, rdy});
    check(tag, "hwdata", HWDATAM, exp_wd);
    @(posedge HCLK);
    if (rdy) begin
      void'(exp_q.pop_front());
      exp_q.push_back((v && tb_trans[mp] != HTRANS_IDLE) ? tb_wdata[mp] : 32'h0);
    end
    @(negedge HCLK);
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      drive_idle(p);
      tb_addr[p]  = 32'h1000_0000 * (p + 1);
      tb_write[p] = 1'b0;
      tb_size[p]  = 3'(p);
      tb_burst[p] = 3'b000;
      tb_prot[p]  = 4'(p + 8);
      tb_wdata[p] = 32'hD0D0_0000 + 32'h0101 * (p + 1);
      tb_held[p]  = 1'b0;
    end
    HRESETn    = 1'b0;
    HREADYOUTM = 1'b1;
    exp_q.push_back(32'h0);
    repeat (2) @(negedge HCLK);
    cycle("reset", 1'b1, PORT_NONE);
    HRESETn = 1'b1;

    // Lone request is granted in the same cycle; write data follows next cycle.
    drive_req(1, HTRANS_NONSEQ, 32'h4000_1000, 3'b000, 1'b0, 1'b1);
    cycle("single", 1'b1, 2'd1);
    drive_idle(1);
    cycle("single_dp", 1'b1, PORT_NONE);

    // Contention after port 2 owned: port 0 wins, port 1 follows.
    drive_req(2, HTRANS_NONSEQ, 32'h2000_0000, 3'b000, 1'b0, 1'b1);
    cycle("c_setup", 1'b1, 2'd2);
    drive_idle(2);
    drive_req(0, HTRANS_NONSEQ, 32'h0000_0100, 3'b000, 1'b0, 1'b1);
    drive_req(1, HTRANS_NONSEQ, 32'h4000_2000, 3'b000, 1'b0, 1'b0);
    cycle("c_both", 1'b1, 2'd0);
    drive_idle(0);
    cycle("c_second", 1'b1, 2'd1);
    drive_idle(1);
    cycle("c_done", 1'b1, PORT_NONE);

    // INCR4 from port 0 with a BUSY beat; port 2 waits until the burst ends.
    drive_req(0, HTRANS_NONSEQ, 32'h0000_0200, 3'b011, 1'b0, 1'b1);
    cycle("b_beat1", 1'b1, 2'd0);
    drive_req(2, HTRANS_NONSEQ, 32'h2000_0100, 3'b001, 1'b0, 1'b1);
    drive_req(0, HTRANS_SEQ, 32'h0000_0204, 3'b011, 1'b0, 1'b1);
    cycle("b_beat2", 1'b1, 2'd0);
    drive_req(0, HTRANS_BUSY, 32'h0000_0208, 3'b011, 1'b0, 1'b1);
    cycle("b_busy", 1'b1, 2'd0);
    drive_req(0, HTRANS_SEQ, 32'h0000_0208, 3'b011, 1'b0, 1'b1);
    cycle("b_beat3", 1'b1, 2'd0);
    drive_req(0, HTRANS_SEQ, 32'h0000_020C, 3'b011, 1'b0, 1'b1);
    cycle("b_beat4", 1'b1, 2'd0);
    drive_idle(0);
    cycle("b_next", 1'b1, 2'd2);

    // Three wait states in port 2's data phase while port 0 requests.
    drive_req(2, HTRANS_SEQ, 32'h2000_0104, 3'b001, 1'b0, 1'b1);
    drive_req(0, HTRANS_NONSEQ, 32'h0000_0300, 3'b000, 1'b0, 1'b1);
    repeat (3) cycle("ws_hold", 1'b0, 2'd2);
    cycle("ws_accept", 1'b1, 2'd2);
    drive_idle(2);
    cycle("ws_after", 1'b1, 2'd0);

    // Locked pair from port 1 keeps the grant against port 0.
    drive_req(0, HTRANS_NONSEQ, 32'h0000_0304, 3'b000, 1'b0, 1'b1);
    drive_req(1, HTRANS_NONSEQ, 32'h4000_3000, 3'b000, 1'b1, 1'b1);
    cycle("lk1", 1'b1, 2'd1);
    drive_req(1, HTRANS_NONSEQ, 32'h4000_3004, 3'b000, 1'b1, 1'b1);
    cycle("lk2", 1'b1, 2'd1);
    drive_idle(1);
    cycle("lk_release", 1'b1, 2'd0);
    drive_idle(0);
    cycle("lk_done", 1'b1, PORT_NONE);

    // Reset in the middle of a port 1 burst.
    drive_req(1, HTRANS_NONSEQ, 32'h4000_4000, 3'b011, 1'b0, 1'b1);
    cycle("r_beat1", 1'b1, 2'd1);
    drive_req(1, HTRANS_SEQ, 32'h4000_4004, 3'b011, 1'b0, 1'b1);
    cycle("r_beat2", 1'b1, 2'd1);
    drive_req(1, HTRANS_SEQ, 32'h4000_4008, 3'b011, 1'b0, 1'b1);
    #2;
    HRESETn = 1'b0;
    for (int p = 0; p < 3; p++) drive_idle(p);
    exp_q.delete();
    exp_q.push_back(32'h0);
    cycle("r_reset", 1'b1, PORT_NONE);
    HRESETn = 1'b1;
    drive_req(2, HTRANS_NONSEQ, 32'h2000_0200, 3'b000, 1'b0, 1'b1);
    cycle("r_grant2", 1'b1, 2'd2);
    drive_idle(2);
    cycle("r_dp", 1'b1, PORT_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
